// File: rtl/instruction_encode.sv
// Packs decoded instruction fields into one head word plus an optional
// extension word, with valid/ready on both sides and running word/instruction counts.
module instruction_encode #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         opcode,
  input  logic [1:0]         mode1,
  input  logic [15:0]        op1,
  input  logic [1:0]         mode2,
  input  logic [15:0]        op2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic               out_last,
  output logic [COUNT_W-1:0] instr_count,
  output logic [COUNT_W-1:0] word_count
);

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    EXT
  } state_t;

  state_t state, state_nx;

  logic [7:0]  opcode_q;
  logic [1:0]  mode1_q;
  logic [15:0] op1_q;
  logic [1:0]  mode2_q;
  logic [15:0] op2_q;

  logic accept;
  logic out_hs;

  always_comb begin
    out_valid = (state != IDLE);
    out_data  = '0;
    out_last  = 1'b0;
    case (state)
      HEAD: begin
        out_data = {(mode1_q == 2'b00) ? 16'h0000 : op1_q, 4'b0000, mode2_q, mode1_q, opcode_q};
        out_last = (mode2_q == 2'b00);
      end
      EXT: begin
        out_data = {16'h0000, op2_q};
        out_last = 1'b1;
      end
      default: ;
    endcase
  end

  // A new bundle can enter in the same cycle the final word leaves, so
  // back-to-back instructions never see a bubble.
  always_comb begin
    out_hs   = out_valid && out_ready;
    in_ready = rst_n && ((state == IDLE) || (out_hs && out_last));
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = HEAD;
      HEAD: begin
        if (out_ready) begin
          if (mode2_q != 2'b00) state_nx = EXT;
          else if (accept)      state_nx = HEAD;
          else                  state_nx = IDLE;
        end
      end
      EXT: begin
        if (out_ready) state_nx = accept ? HEAD : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      opcode_q    <= '0;
      mode1_q     <= '0;
      op1_q       <= '0;
      mode2_q     <= '0;
      op2_q       <= '0;
      instr_count <= '0;
      word_count  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        opcode_q <= opcode;
        mode1_q  <= mode1;
        op1_q    <= op1;
        mode2_q  <= mode2;
        op2_q    <= op2;
      end
      if (out_hs) begin
        word_count <= word_count + COUNT_W'(1);
        if (out_last) instr_count <= instr_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_encode.sv
// Scoreboard bench for instruction_encode: stimulus pushes expected words,
// a negedge monitor pops and compares every output handshake.
module tb_instruction_encode;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    opcode = '0;
  logic [1:0]    mode1 = '0;
  logic [15:0]   op1 = '0;
  logic [1:0]    mode2 = '0;
  logic [15:0]   op2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          out_last;
  logic [CW-1:0] instr_count;
  logic [CW-1:0] word_count;

  instruction_encode #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .mode1(mode1), .op1(op1), .mode2(mode2), .op2(op2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .instr_count(instr_count), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer readiness: forced value or random per cycle.
  logic ready_mode  = 1'b0;
  logic ready_force = 1'b0;
  always @(posedge clk) begin
    #2;
    out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Scoreboard: {last, word}
  logic [32:0] exp_q[$];
  int          hs_cyc[$];
  int          cyc = 0;
  int          exp_wc = 0;
  int          exp_ic = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [32:0] e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      exp_wc = 0;
      exp_ic = 0;
      prev_stall = 1'b0;
    end else begin
      check("word_count", 32'(word_count), 32'(exp_wc % (1 << CW)));
      check("instr_count", 32'(instr_count), 32'(exp_ic % (1 << CW)));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        exp_wc++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_data, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[31:0]);
          check("out_last", 32'(out_last), 32'(e[32]));
          if (e[32]) exp_ic++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Reference: words built from the field rules with plain arithmetic.
  task automatic push_expected(input logic [7:0] opc, input logic [1:0] m1, input logic [15:0] o1,
                               input logic [1:0] m2, input logic [15:0] o2);
    int unsigned h;
    h = int'(opc) + int'(m1) * 256 + int'(m2) * 1024;
    if (m1 != 2'b00) h = h + int'(o1) * 65536;
    exp_q.push_back({(m2 == 2'b00), 32'(h)});
    if (m2 != 2'b00) exp_q.push_back({1'b1, 32'(int'(o2))});
  endtask

  // Enter at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] opc, input logic [1:0] m1, input logic [15:0] o1,
                      input logic [1:0] m2, input logic [15:0] o2);
    bit got = 0;
    opcode = opc; mode1 = m1; op1 = o1; mode2 = m2; op2 = o2;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        push_expected(opc, m1, o1, m2, o2);
      end
      @(posedge clk); #1;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int idx0;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_instr_count", 32'(instr_count), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    ready_force = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    step();

    // Single-word instruction
    send(8'h12, 2'b01, 16'hBEEF, 2'b00, 16'h0);
    @(negedge clk);
    check("single_data", out_data, 32'hBEEF0112);
    check("single_last", 32'(out_last), 32'd1);
    step();
    @(negedge clk);
    check("single_icount", 32'(instr_count), 32'd1);
    check("single_wcount", 32'(word_count), 32'd1);
    step();

    // Two-word instruction
    send(8'hA5, 2'b10, 16'h1234, 2'b11, 16'hCAFE);
    @(negedge clk);
    check("two_head_data", out_data, 32'h12340EA5);
    check("two_head_last", 32'(out_last), 32'd0);
    check("two_head_in_ready", 32'(in_ready), 32'd0);
    step();
    @(negedge clk);
    check("two_ext_data", out_data, 32'h0000CAFE);
    check("two_ext_last", 32'(out_last), 32'd1);
    step();

    // Operand-1 masking
    send(8'h01, 2'b00, 16'hFFFF, 2'b00, 16'h0);
    @(negedge clk);
    check("mask_data", out_data, 32'h00000001);
    step();

    // Backpressure on a head word
    ready_force = 1'b0;
    send(8'h7E, 2'b11, 16'h5555, 2'b00, 16'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_data", out_data, 32'h5555037E);
      check("bp_last", 32'(out_last), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_icount", 32'(instr_count), 32'd3);
      check("bp_wcount", 32'(word_count), 32'd4);
      step();
    end
    ready_force = 1'b1;
    wait_drain();
    @(negedge clk);
    check("bp_icount_after", 32'(instr_count), 32'd4);
    check("bp_wcount_after", 32'(word_count), 32'd5);
    step();

    // Reset while an extension word is pending
    ready_force = 1'b0;
    send(8'hC3, 2'b01, 16'h0101, 2'b10, 16'h2222);
    ready_force = 1'b1;
    step();
    ready_force = 1'b0;
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'h0);
    check("midrst_icount", 32'(instr_count), 32'd0);
    check("midrst_wcount", 32'(word_count), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst_n = 1'b1;
    ready_force = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_rel", 32'(in_ready), 32'd1);
    check("midrst_no_ext", 32'(out_valid), 32'd0);
    repeat (3) step();

    // Streaming 20 single-word instructions, counter wrap
    idx0 = hs_cyc.size();
    for (int i = 0; i < 20; i++)
      send(8'($urandom), 2'($urandom), 16'($urandom), 2'b00, 16'($urandom));
    wait_drain();
    check("stream_words", 32'(hs_cyc.size() - idx0), 32'd20);
    if (hs_cyc.size() - idx0 == 20)
      check("stream_no_bubble", 32'(hs_cyc[idx0 + 19] - hs_cyc[idx0]), 32'd19);
    @(negedge clk);
    check("stream_icount", 32'(instr_count), 32'd4);
    check("stream_wcount", 32'(word_count), 32'd4);
    step();

    // Random mix with random consumer stalls
    ready_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(8'($urandom), 2'($urandom), 16'($urandom), 2'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    ready_mode = 1'b0;
    ready_force = 1'b1;
    wait_drain();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
